// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The FSM encoding is shared so the top and any debug taps agree on state values.
package imem_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    DONE,
    ERR
  } ldr_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = byte source plus memory.
interface imem_loader_if #(
  parameter int A_WIDTH = 8,
  parameter int BYTE_W  = 8
);

  localparam int WIDTH = 4 * BYTE_W;

  logic               byte_valid;
  logic [BYTE_W-1:0]  byte_data;
  logic               byte_ready;
  logic               wr_en;
  logic [A_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]   wr_data;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles four stream bytes into one little-endian word; lane 0 lands in bits [7:0].
// One cycle per byte insert; clear wins over load so a new session never sees stale bytes.
module byte_packer #(
  parameter int BYTE_W = 8,
  parameter int WIDTH  = 4 * BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [1:0]        lane,
  input  logic [BYTE_W-1:0] din,
  output logic [WIDTH-1:0]  word
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
    end else if (clr) begin
      word <= '0;
    end else if (load) begin
      word[lane*BYTE_W +: BYTE_W] <= din;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory as 32-bit words from address 0,
// holding the core in reset until the whole image is written; one WRITE cycle per word stalls the stream.
module imem_loader #(
  parameter int WIDTH   = 32,
  parameter int A_WIDTH = 8,
  parameter int BYTE_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_loader_if.master       bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);

  import imem_loader_pkg::*;

  localparam int        CNT_W   = 17;
  localparam int        DEPTH   = 1 << A_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(DEPTH);

  ldr_state_t          state, state_nxt;
  logic [BYTE_W-1:0]   hdr_lo;
  logic [15:0]         hdr_n;
  logic [15:0]         n_in;
  logic [1:0]          byte_idx;
  logic [A_WIDTH:0]    word_idx;
  logic [WIDTH-1:0]    word;
  logic                xfer;
  logic                start_ok;
  logic                last_word;

  assign start_ok  = start && (state == IDLE || state == DONE || state == ERR);
  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign n_in      = {byte_data_hi(bus.byte_data), hdr_lo};
  assign last_word = (CNT_W'(word_idx) + CNT_W'(1)) == {1'b0, hdr_n};

  function automatic logic [7:0] byte_data_hi(input logic [BYTE_W-1:0] b);
    return 8'(b);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_ok) state_nxt = HDR0;
      HDR0:  if (xfer) state_nxt = HDR1;
      HDR1: begin
        if (xfer) begin
          if (n_in == 16'd0)                 state_nxt = DONE;
          else if ({1'b0, n_in} > DEPTH_V)   state_nxt = ERR;
          else                               state_nxt = DATA;
        end
      end
      DATA:  if (xfer && byte_idx == 2'(BYTES_PER_WORD - 1)) state_nxt = WRITE;
      WRITE: state_nxt = last_word ? DONE : DATA;
      DONE:  if (start_ok) state_nxt = HDR0;
      ERR:   if (start_ok) state_nxt = HDR0;
      default: state_nxt = IDLE;
    endcase
  end

  // Header and counters; word_idx is one bit wider so N == DEPTH never aliases to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_lo   <= '0;
      hdr_n    <= '0;
      byte_idx <= '0;
      word_idx <= '0;
    end else if (start_ok) begin
      byte_idx <= '0;
      word_idx <= '0;
    end else begin
      if (state == HDR0 && xfer) hdr_lo <= bus.byte_data;
      if (state == HDR1 && xfer) hdr_n <= n_in;
      if (state == DATA && xfer) byte_idx <= byte_idx + 2'd1;
      if (state == WRITE)        word_idx <= word_idx + 1'b1;
    end
  end

  byte_packer #(
    .BYTE_W (BYTE_W),
    .WIDTH  (WIDTH)
  ) u_packer (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_ok),
    .load (xfer && state == DATA),
    .lane (byte_idx),
    .din  (bus.byte_data),
    .word (word)
  );

  assign bus.byte_ready = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign bus.wr_en      = (state == WRITE);
  assign bus.wr_addr    = bus.wr_en ? word_idx[A_WIDTH-1:0] : '0;
  assign bus.wr_data    = bus.wr_en ? word : '0;

  assign cpu_hold = (state != DONE);
  assign done     = (state == DONE);
  assign error    = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: scoreboard of expected memory writes checked by a write monitor,
// plus status checks at session boundaries.
module tb_imem_loader;

  localparam int A_WIDTH = 8;
  localparam int BYTE_W  = 8;
  localparam int WIDTH   = 32;

  logic clk;
  logic rst;
  logic start;
  logic cpu_hold;
  logic done;
  logic error;

  int checks;
  int failures;
  int wr_pulses;
  logic [A_WIDTH+WIDTH-1:0] exp_q[$];

  imem_loader_if #(.A_WIDTH(A_WIDTH), .BYTE_W(BYTE_W)) bus ();

  imem_loader #(
    .WIDTH   (WIDTH),
    .A_WIDTH (A_WIDTH),
    .BYTE_W  (BYTE_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus.master),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every wr_en pulse must match the head of the scoreboard and stall the stream.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.wr_en === 1'b1) begin
      wr_pulses++;
      chk("ready_low_in_write", 64'(bus.byte_ready), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'({bus.wr_addr, bus.wr_data}), 64'd0);
      end else begin
        logic [A_WIDTH+WIDTH-1:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.wr_addr), 64'(e[A_WIDTH+WIDTH-1:WIDTH]));
        chk("wr_data", 64'(bus.wr_data), 64'(e[WIDTH-1:0]));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Presents one byte (after an optional idle gap) and returns #1 after the edge that consumed it.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("byte_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 bus.byte_valid = 1'b0;
  endtask

  task automatic send_image(input logic [7:0] img[], input bit gaps);
    foreach (img[i]) send_byte(img[i], gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  initial begin
    logic [7:0] img2[];
    logic [7:0] img1[];
    int base;
    checks = 0;
    failures = 0;
    wr_pulses = 0;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    rst = 1'b1;
    #2 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_byte_ready", 64'(bus.byte_ready), 64'd0);
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
    chk("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_byte_ready", 64'(bus.byte_ready), 64'd0);
    chk("idle_cpu_hold", 64'(cpu_hold), 64'd1);
    chk("idle_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;

    // Two-word image, back-to-back bytes
    img2 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h11, 8'h00};
    exp_q.push_back({8'd0, 32'h00500093});
    exp_q.push_back({8'd1, 32'h00110113});
    pulse_start();
    chk("session_hold", 64'(cpu_hold), 64'd1);
    send_image(img2, 1'b0);
    @(negedge clk);
    chk("last_wr_en", 64'(bus.wr_en), 64'd1);
    @(negedge clk);
    chk("img2_done", 64'(done), 64'd1);
    chk("img2_cpu_hold", 64'(cpu_hold), 64'd0);
    chk("img2_all_written", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // Same image with random source gaps; start from DONE re-asserts hold
    exp_q.push_back({8'd0, 32'h00500093});
    exp_q.push_back({8'd1, 32'h00110113});
    pulse_start();
    chk("restart_hold", 64'(cpu_hold), 64'd1);
    chk("restart_done_clr", 64'(done), 64'd0);
    send_image(img2, 1'b1);
    repeat (2) @(negedge clk);
    chk("gap_done", 64'(done), 64'd1);
    chk("gap_all_written", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // Empty image
    base = wr_pulses;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    chk("empty_done", 64'(done), 64'd1);
    chk("empty_no_writes", 64'(wr_pulses - base), 64'd0);
    @(posedge clk);
    #1;

    // Oversized header N=257, then recovery
    base = wr_pulses;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    chk("ovf_error", 64'(error), 64'd1);
    chk("ovf_cpu_hold", 64'(cpu_hold), 64'd1);
    chk("ovf_ready", 64'(bus.byte_ready), 64'd0);
    repeat (2) @(negedge clk);
    chk("ovf_no_writes", 64'(wr_pulses - base), 64'd0);
    @(posedge clk);
    #1;
    img1 = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    exp_q.push_back({8'd0, 32'h12345678});
    pulse_start();
    send_image(img1, 1'b0);
    repeat (2) @(negedge clk);
    chk("recover_done", 64'(done), 64'd1);
    chk("recover_error", 64'(error), 64'd0);
    chk("recover_written", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // Reset mid-word discards the partial word
    base = wr_pulses;
    pulse_start();
    send_image('{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC}, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_ready", 64'(bus.byte_ready), 64'd0);
    chk("midrst_hold", 64'(cpu_hold), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_writes", 64'(wr_pulses - base), 64'd0);
    chk("midrst_idle_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    exp_q.push_back({8'd0, 32'hDEADBEEF});
    pulse_start();
    send_image('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 1'b0);
    repeat (2) @(negedge clk);
    chk("deadbeef_done", 64'(done), 64'd1);
    chk("deadbeef_written", 64'(exp_q.size()), 64'd0);
    chk("total_writes", 64'(wr_pulses), 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
